text_console_buffer: RTL and testbench
======================================

// Module: text_console_buffer
// PURPOSE
//  Parametrised character buffer for the text-mode video path; successor to the fixed 80x30 buffer.
//  The write side is a cursor-driven console stream with auto-advance, newline, hardware scroll and full clear.
//  The read side maps the dot/scanline counters to a character cell and returns its code for the glyph renderer.
// PARAMETERS
//  CHAR_W       8    bits per character code
//  COLS         80   text columns
//  ROWS         30   text rows
//  CELL_W_LOG2  3    log2 pixel width of a cell (8 px)
//  CELL_H_LOG2  4    log2 scanline height of a cell (16 lines)
//  H_W          10   width of dot_counter
//  V_W          9    width of scanline_counter
//  BLANK        0    code written by clear/scroll and returned outside the text area
// PORTS
//  clk               in   1       system clock
//  rst_n             in   1       asynchronous active-low reset
//  wr_char           in   CHAR_W  character to store at the cursor
//  wr_valid          in   1       write request; accepted when wr_valid && wr_ready
//  newline           in   1       move cursor to column 0 of the next row; accepted when wr_ready
//  clear_req         in   1       pulse: blank the whole screen, home the cursor
//  wr_ready          out  1       1 in IDLE only
//  busy              out  1       1 in CLEAR or SCROLL_CLR
//  cursor_col        out  clog2(COLS)  current cursor column
//  cursor_row        out  clog2(ROWS)  current logical cursor row
//  dot_counter       in   H_W     current pixel x
//  scanline_counter  in   V_W     current pixel y
//  char              out  CHAR_W  code of the cell under (dot, scanline); registered
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-low.
//  - Storage is ROWS*COLS words of CHAR_W bits with one write and one read per cycle.
//    Memory contents are not reset.
//  - Reset values: state=CLEAR, clr_ptr=0, cursor=(0,0), top_row=0, char=BLANK.
//    Outputs during reset: busy=1, wr_ready=0, clear_pend=0.
//  - Logical row r is stored at physical row p=(top_row+r), minus ROWS if >=ROWS.
//    Address = p*COLS+col.
//  - FSM: IDLE, CLEAR, SCROLL_CLR.
//  - CLEAR:
//    - Writes BLANK to address clr_ptr, one per cycle, from 0 to ROWS*COLS-1. Exactly ROWS*COLS cycles.
//    - On exit: cursor=(0,0), top_row=0, state goes to IDLE.
//  - IDLE priority when requests coincide in the same cycle: clear_req > newline > wr_valid.
//    Lower-priority requests in that cycle are dropped.
//  - Accepted write:
//    - Stores wr_char at the cursor.
//    - Cursor advances col+1. At col==COLS-1 it wraps to col 0 and row+1.
//  - Accepted newline: cursor goes to col 0, row+1.
//  - Row advance from row==ROWS-1:
//    - top_row = top_row+1 mod ROWS; cursor_row stays ROWS-1, col 0.
//    - Enter SCROLL_CLR, which writes BLANK to the new bottom physical row. Exactly COLS cycles, then IDLE.
//  - clear_req while busy is latched in clear_pend. It enters CLEAR the cycle after the current op ends.
//  - wr_valid or newline while wr_ready=0 are ignored. No buffering.
//  - Read path:
//    - cell_col = dot_counter>>CELL_W_LOG2; cell_row = scanline_counter>>CELL_H_LOG2.
//    - If cell_col>=COLS or cell_row>=ROWS, char=BLANK.
//    - Otherwise char = mem[phys(cell_row)*COLS+cell_col].
//    - Latency: 1 clock from the counters to char.
//  - Read and write to the same address in the same cycle: char returns the old data (read-before-write).
//  - The read side runs continuously; during CLEAR/SCROLL_CLR it shows partially blanked content.
//  - Reset asserted mid-operation aborts immediately; after release the full CLEAR reruns.
//  - Row-index arithmetic uses one conditional subtract; no divider. Multiply by COLS is constant.
// TESTING
//  1 Reset, release -> busy=1 for exactly 2400 cycles, then wr_ready=1; full 640x480 sweep gives char==0x00.
//  2 Write 0x41 x3 -> cursor=(3,0); dot=16,scan=0 -> char=0x41 next clk; dot=24 -> 0x00; dot=640 -> 0x00.
//  3 Write 80 chars -> cursor=(0,1); 5 writes then newline -> cursor=(0,2); wr_valid+newline same cycle -> newline only.
//  4 Fill to (79,29), write 0x5A, row 1 holds 0x31 -> busy 80 cycles; after: scan=0 shows 0x31, scan=464 shows 0x00, cursor=(0,29).
//  5 clear_req+wr_valid same cycle -> write dropped, 2400 busy cycles; clear_req mid-scroll -> CLEAR follows scroll; end cursor=(0,0).
//  6 rst_n low mid-SCROLL_CLR -> busy=1, cursor=(0,0), top_row=0 immediately; 2400-cycle CLEAR reruns after release.

Source files
------------

// File: rtl/text_console_buffer_if.sv
// Console write-side bundle: character stream, control requests and cursor/status feedback.
interface text_console_buffer_if #(
  parameter int CHAR_W = 8,
  parameter int COLS   = 80,
  parameter int ROWS   = 30
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [CHAR_W-1:0] wr_char;
  logic              wr_valid;
  logic              newline;
  logic              clear_req;
  logic              wr_ready;
  logic              busy;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;

  modport master (
    output wr_char, wr_valid, newline, clear_req,
    input  wr_ready, busy, cursor_col, cursor_row
  );

  modport slave (
    input  wr_char, wr_valid, newline, clear_req,
    output wr_ready, busy, cursor_col, cursor_row
  );
endinterface

// File: rtl/text_console_buffer.sv
// Text-mode character buffer: cursor-driven console writes with hardware scroll on the write side,
// dot/scanline-addressed registered character lookup on the read side.
module text_console_buffer #(
  parameter int CHAR_W      = 8,
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int CELL_W_LOG2 = 3,
  parameter int CELL_H_LOG2 = 4,
  parameter int H_W         = 10,
  parameter int V_W         = 9,
  parameter int BLANK       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  text_console_buffer_if.slave con,
  input  logic [H_W-1:0]       dot_counter,
  input  logic [V_W-1:0]       scanline_counter,
  output logic [CHAR_W-1:0]    char
);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CHAR_W-1:0] BLANK_C = CHAR_W'(BLANK);

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_CLR} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  clr_ptr, clr_ptr_n;
  logic [COL_W-1:0]   col, col_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [ROW_W-1:0]   top_row, top_n;
  logic               clear_pend, clear_pend_n;
  logic               row_adv;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [CHAR_W-1:0]  wdata;

  logic [CHAR_W-1:0]  mem [DEPTH];

  // Logical-to-physical row rotation; both operands are < ROWS so one subtract suffices.
  function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] top, input logic [ROW_W-1:0] r);
    logic [ROW_W:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] p, input logic [COL_W-1:0] c);
    return ADDR_W'(p) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  always_comb begin
    state_n      = state;
    clr_ptr_n    = clr_ptr;
    col_n        = col;
    row_n        = row;
    top_n        = top_row;
    clear_pend_n = clear_pend;
    row_adv      = 1'b0;
    we           = 1'b0;
    waddr        = cell_addr(phys(top_row, row), col);
    wdata        = BLANK_C;
    case (state)
      IDLE: begin
        if (con.clear_req) begin
          state_n   = CLEAR;
          clr_ptr_n = '0;
        end else if (con.newline) begin
          row_adv = 1'b1;
        end else if (con.wr_valid) begin
          we    = 1'b1;
          wdata = con.wr_char;
          if (col == COL_W'(COLS-1)) row_adv = 1'b1;
          else col_n = col + 1'b1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr;
        if (con.clear_req) clear_pend_n = 1'b1;
        if (clr_ptr == ADDR_W'(DEPTH-1)) begin
          clr_ptr_n    = '0;
          col_n        = '0;
          row_n        = '0;
          top_n        = '0;
          state_n      = clear_pend_n ? CLEAR : IDLE;
          clear_pend_n = 1'b0;
        end else begin
          clr_ptr_n = clr_ptr + 1'b1;
        end
      end
      SCROLL_CLR: begin
        // top_row has already advanced, so the cursor row now maps onto the stale physical row.
        we    = 1'b1;
        waddr = cell_addr(phys(top_row, row), clr_ptr[COL_W-1:0]);
        if (con.clear_req) clear_pend_n = 1'b1;
        if (clr_ptr == ADDR_W'(COLS-1)) begin
          clr_ptr_n    = '0;
          state_n      = clear_pend_n ? CLEAR : IDLE;
          clear_pend_n = 1'b0;
        end else begin
          clr_ptr_n = clr_ptr + 1'b1;
        end
      end
      default: state_n = CLEAR;
    endcase
    if (row_adv) begin
      col_n = '0;
      if (row == ROW_W'(ROWS-1)) begin
        top_n     = (top_row == ROW_W'(ROWS-1)) ? '0 : top_row + 1'b1;
        state_n   = SCROLL_CLR;
        clr_ptr_n = '0;
      end else begin
        row_n = row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      col        <= '0;
      row        <= '0;
      top_row    <= '0;
      clear_pend <= 1'b0;
    end else begin
      state      <= state_n;
      clr_ptr    <= clr_ptr_n;
      col        <= col_n;
      row        <= row_n;
      top_row    <= top_n;
      clear_pend <= clear_pend_n;
    end
  end

  assign con.wr_ready   = (state == IDLE);
  assign con.busy       = (state != IDLE);
  assign con.cursor_col = col;
  assign con.cursor_row = row;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [H_W-1:0]    cell_col;
  logic [V_W-1:0]    cell_row;
  logic              in_area;
  logic [ADDR_W-1:0] raddr;

  assign cell_col = dot_counter >> CELL_W_LOG2;
  assign cell_row = scanline_counter >> CELL_H_LOG2;
  assign in_area  = (cell_col < H_W'(COLS)) && (cell_row < V_W'(ROWS));
  assign raddr    = cell_addr(phys(top_row, cell_row[ROW_W-1:0]), cell_col[COL_W-1:0]);

  // Same-cycle read of a cell being written returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char <= BLANK_C;
    else        char <= in_area ? mem[raddr] : BLANK_C;
  end
endmodule

// File: tb/tb_text_console_buffer.sv
// Self-checking bench for text_console_buffer: cursor/scroll/clear sequencing and the registered read path.
module tb_text_console_buffer;
  localparam int CHAR_W = 8;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int H_W    = 10;
  localparam int V_W    = 9;
  localparam int DEPTH  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [H_W-1:0]    dot = '0;
  logic [V_W-1:0]    scan = '0;
  logic [CHAR_W-1:0] char;

  text_console_buffer_if #(.CHAR_W(CHAR_W), .COLS(COLS), .ROWS(ROWS)) con ();

  text_console_buffer #(.CHAR_W(CHAR_W), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .con              (con),
    .dot_counter      (dot),
    .scanline_counter (scan),
    .char             (char)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [CHAR_W-1:0] sb[$];

  function automatic logic [11:0] rc(input int r, input int c);
    return {5'(r), 7'(c)};
  endfunction

  task automatic put_char(input logic [CHAR_W-1:0] c);
    con.wr_char  = c;
    con.wr_valid = 1'b1;
    @(negedge clk);
    con.wr_valid = 1'b0;
  endtask

  task automatic put_newline();
    con.newline = 1'b1;
    @(negedge clk);
    con.newline = 1'b0;
  endtask

  task automatic put_clear();
    con.clear_req = 1'b1;
    @(negedge clk);
    con.clear_req = 1'b0;
  endtask

  // Drive one read probe and queue its expected char; the registered result is visible on return.
  task automatic probe(input int x, input int y, input logic [CHAR_W-1:0] e);
    dot  = H_W'(x);
    scan = V_W'(y);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (con.busy && cycles < 5000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [CHAR_W-1:0] got, exp;
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (con.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_busy got=%b exp=1", con.busy); end
    n_cmp++; if (con.wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready got=%b exp=0", con.wr_ready); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 0)) begin n_fail++; $display("[TB] FAIL rst_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 0)); end
    n_cmp++; if (char !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_char got=%h exp=00", char); end
    rst_n = 1'b1;
    wait_idle(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_fail++; $display("[TB] FAIL init_clear_len got=%0d exp=%0d", cyc, DEPTH); end
    n_cmp++; if (con.wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL init_ready got=%b exp=1", con.wr_ready); end
    for (int r = 0; r <= ROWS; r++) begin
      for (int c = 0; c <= COLS; c++) begin
        probe(c*8 + (c%8), r*16 + (r%16), 8'h00);
        got = char; exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL sweep (%0d,%0d) got=%h exp=%h", c, r, got, exp); end
      end
    end
    probe(1023, 511, 8'h00);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL sweep_corner got=%h exp=%h", got, exp); end
  endtask

  task automatic test_write_read();
    logic [CHAR_W-1:0] got, exp;
    int t[21] = '{16,0,'h41, 0,15,'h41, 23,7,'h41, 24,0,'h00, 640,0,'h00, 16,16,'h00, 16,480,'h00};
    repeat (3) put_char(8'h41);
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 3)) begin n_fail++; $display("[TB] FAIL write3_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 3)); end
    for (int i = 0; i < 21; i += 3) begin
      probe(t[i], t[i+1], 8'(t[i+2]));
      got = char; exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL write3_read (%0d,%0d) got=%h exp=%h", t[i], t[i+1], got, exp); end
    end
    dot = 24; scan = 0;
    sb.push_back(8'h00);
    con.wr_char = 8'h42; con.wr_valid = 1'b1;
    @(negedge clk);
    con.wr_valid = 1'b0;
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL rbw_old got=%h exp=%h", got, exp); end
    sb.push_back(8'h42);
    @(negedge clk);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL rbw_new got=%h exp=%h", got, exp); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 4)) begin n_fail++; $display("[TB] FAIL rbw_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 4)); end
  endtask

  task automatic test_wrap_newline();
    logic [CHAR_W-1:0] got, exp;
    int cyc;
    int t[18] = '{632,0,'h50, 0,0,'h01, 0,16,'h61, 32,16,'h65, 40,16,'h00, 0,32,'h00};
    put_clear();
    wait_idle(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_fail++; $display("[TB] FAIL clear_len got=%0d exp=%0d", cyc, DEPTH); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 0)) begin n_fail++; $display("[TB] FAIL clear_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 0)); end
    for (int i = 0; i < COLS; i++) put_char(8'(i + 1));
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(1, 0)) begin n_fail++; $display("[TB] FAIL wrap_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(1, 0)); end
    for (int i = 0; i < 5; i++) put_char(8'(8'h61 + i));
    put_newline();
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(2, 0)) begin n_fail++; $display("[TB] FAIL newline_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(2, 0)); end
    con.wr_char = 8'h7E; con.wr_valid = 1'b1; con.newline = 1'b1;
    @(negedge clk);
    con.wr_valid = 1'b0; con.newline = 1'b0;
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(3, 0)) begin n_fail++; $display("[TB] FAIL prio_nl_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(3, 0)); end
    for (int i = 0; i < 18; i += 3) begin
      probe(t[i], t[i+1], 8'(t[i+2]));
      got = char; exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL wrap_read (%0d,%0d) got=%h exp=%h", t[i], t[i+1], got, exp); end
    end
  endtask

  task automatic test_scroll();
    logic [CHAR_W-1:0] got, exp;
    int cyc;
    int t[21] = '{0,0,'h31, 632,0,'h31, 0,16,'h32, 632,448,'h5A, 0,448,'h4D, 0,464,'h00, 632,464,'h00};
    put_clear();
    wait_idle(cyc);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == ROWS-1 && c == COLS-1)) put_char(8'(8'h30 + r));
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(29, 79)) begin n_fail++; $display("[TB] FAIL fill_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(29, 79)); end
    put_char(8'h5A);
    wait_idle(cyc);
    n_cmp++; if (cyc !== COLS) begin n_fail++; $display("[TB] FAIL scroll_len got=%0d exp=%0d", cyc, COLS); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(29, 0)) begin n_fail++; $display("[TB] FAIL scroll_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(29, 0)); end
    for (int i = 0; i < 21; i += 3) begin
      probe(t[i], t[i+1], 8'(t[i+2]));
      got = char; exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL scroll_read (%0d,%0d) got=%h exp=%h", t[i], t[i+1], got, exp); end
    end
    put_char(8'h7A);
    probe(0, 464, 8'h7A);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL post_scroll_write got=%h exp=%h", got, exp); end
  endtask

  task automatic test_clear_priority();
    logic [CHAR_W-1:0] got, exp;
    int cyc, cnt;
    con.clear_req = 1'b1; con.wr_valid = 1'b1; con.wr_char = 8'h55;
    @(negedge clk);
    con.clear_req = 1'b0; con.wr_valid = 1'b0;
    wait_idle(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_fail++; $display("[TB] FAIL prio_clear_len got=%0d exp=%0d", cyc, DEPTH); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 0)) begin n_fail++; $display("[TB] FAIL prio_clear_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 0)); end
    probe(0, 464, 8'h00);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL prio_clear_read got=%h exp=%h", got, exp); end
    repeat (ROWS-1) put_newline();
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(29, 0)) begin n_fail++; $display("[TB] FAIL nl29_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(29, 0)); end
    put_newline();
    cnt = 0;
    repeat (10) begin
      if (con.busy) cnt++;
      @(negedge clk);
    end
    con.clear_req = 1'b1;
    if (con.busy) cnt++;
    @(negedge clk);
    con.clear_req = 1'b0;
    wait_idle(cyc);
    cnt += cyc;
    n_cmp++; if (cnt !== COLS + DEPTH) begin n_fail++; $display("[TB] FAIL scroll_then_clear_len got=%0d exp=%0d", cnt, COLS + DEPTH); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 0)) begin n_fail++; $display("[TB] FAIL scroll_then_clear_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 0)); end
  endtask

  task automatic test_reset_mid_scroll();
    logic [CHAR_W-1:0] got, exp;
    int cyc;
    put_char(8'h77);
    repeat (ROWS-1) put_newline();
    put_newline();
    con.wr_char = 8'h33; con.wr_valid = 1'b1; con.newline = 1'b1;
    @(negedge clk);
    con.wr_valid = 1'b0; con.newline = 1'b0;
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(29, 0)) begin n_fail++; $display("[TB] FAIL busy_ignore_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(29, 0)); end
    n_cmp++; if (con.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL scroll_busy got=%b exp=1", con.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (con.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy got=%b exp=1", con.busy); end
    n_cmp++; if (con.wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready got=%b exp=0", con.wr_ready); end
    n_cmp++; if ({con.cursor_row, con.cursor_col} !== rc(0, 0)) begin n_fail++; $display("[TB] FAIL midrst_cursor got=%h exp=%h", {con.cursor_row, con.cursor_col}, rc(0, 0)); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_fail++; $display("[TB] FAIL midrst_clear_len got=%0d exp=%0d", cyc, DEPTH); end
    probe(0, 0, 8'h00);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL midrst_read_blank got=%h exp=%h", got, exp); end
    put_char(8'h5A);
    probe(0, 0, 8'h5A);
    got = char; exp = sb.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("[TB] FAIL midrst_read_write got=%h exp=%h", got, exp); end
  endtask

  initial begin
    con.wr_char = '0; con.wr_valid = 1'b0; con.newline = 1'b0; con.clear_req = 1'b0;
    test_reset();
    test_write_read();
    test_wrap_newline();
    test_scroll();
    test_clear_priority();
    test_reset_mid_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule
